// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM state types and a
// constant-width helper used to size register-bank decode fields.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Smallest n with 2**n >= value; constant-evaluable for parameter math.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/axi4_lite_regbank.sv
// Word register storage with byte-strobe writes; read-only words are not stored
// and are sourced from i_reg_in on the read path (they show as zero on o_reg_out).
module axi4_lite_regbank
  import axi4_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] REG_RESET  = '0,
  localparam int                   IDX_W      = clog2(NUM_REGS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_wr_en,
  input  logic [IDX_W-1:0]               i_wr_idx,
  input  logic [DATA_WIDTH-1:0]          i_wr_data,
  input  logic [DATA_WIDTH/8-1:0]        i_wr_strb,
  input  logic [IDX_W-1:0]               i_rd_idx,
  output logic [DATA_WIDTH-1:0]          o_rd_data,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] i_reg_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_out
);

  logic [DATA_WIDTH-1:0] w_rd_words [NUM_REGS];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_word
    if (RO_MASK[gi]) begin : g_ro
      assign o_reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      assign w_rd_words[gi] = i_reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] r_word;
      logic                  w_unused_reg_in;

      // NOTE: this storage is reset on purpose: software expects every writable
      // word to read back REG_RESET, so it cannot be left as an unreset RAM.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_word <= REG_RESET;
        end else if (i_wr_en && (i_wr_idx == IDX_W'(gi))) begin
          for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (i_wr_strb[b]) r_word[b*8 +: 8] <= i_wr_data[b*8 +: 8];
          end
        end
      end

      assign o_reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_word;
      assign w_rd_words[gi]  = r_word;
      assign w_unused_reg_in = ^i_reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_rd_data = w_rd_words[i_rd_idx];

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave front end: independent AW/W capture, write/read channel FSMs
// and address/permission decode in front of axi4_lite_regbank.
module axi4_lite_regfile_slave
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] REG_RESET  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_OUT,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] REG_IN
);

  localparam int LSB   = clog2(DATA_WIDTH/8);
  localparam int IDX_W = clog2(NUM_REGS);

  function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic is_write);
    if (addr[ADDR_WIDTH-1:LSB+IDX_W] != '0) return RESP_DECERR;
    if (is_write && RO_MASK[addr[LSB +: IDX_W]]) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  wr_state_t r_wstate, w_wstate_nxt;
  rd_state_t r_rstate, w_rstate_nxt;

  logic                    r_in_reset;
  logic                    r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic [1:0]              r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic                    w_aw_hs, w_w_hs, w_ar_hs, w_wr_fire, w_wr_en;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic [DATA_WIDTH-1:0]   w_wr_data, w_bank_rdata;
  logic [DATA_WIDTH/8-1:0] w_wr_strb;
  logic [1:0]              w_wr_resp, w_rd_resp;
  logic                    w_unused_lsbs;

  // READYs come only from registered state so no input reaches them combinationally;
  // r_in_reset keeps them low for every cycle ARESET is held.
  assign AWREADY = (r_wstate == W_IDLE) && !r_aw_held && !r_in_reset;
  assign WREADY  = (r_wstate == W_IDLE) && !r_w_held  && !r_in_reset;
  assign ARREADY = (r_rstate == R_IDLE) && !r_in_reset;

  assign w_aw_hs   = AWVALID && AWREADY;
  assign w_w_hs    = WVALID  && WREADY;
  assign w_ar_hs   = ARVALID && ARREADY;
  assign w_wr_addr = r_aw_held ? r_awaddr : AWADDR;
  assign w_wr_data = r_w_held  ? r_wdata  : WDATA;
  assign w_wr_strb = r_w_held  ? r_wstrb  : WSTRB;
  assign w_wr_fire = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_resp = decode_resp(w_wr_addr, 1'b1);
  assign w_wr_en   = w_wr_fire && (w_wr_resp == RESP_OKAY);
  assign w_rd_resp = decode_resp(ARADDR, 1'b0);
  assign w_unused_lsbs = ^{w_wr_addr[LSB-1:0], ARADDR[LSB-1:0]};

  // NOTE: all clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_in_reset <= 1'b1;
      r_wstate   <= W_IDLE;
      r_rstate   <= R_IDLE;
    end else begin
      r_in_reset <= 1'b0;
      r_wstate   <= w_wstate_nxt;
      r_rstate   <= w_rstate_nxt;
    end
  end

  // NOTE: next-state defaults come first so no path leaves a variable unassigned
  // (which would infer a latch).
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_rstate_nxt = r_rstate;
    case (r_wstate)
      W_IDLE:  if (w_wr_fire) w_wstate_nxt = W_RESP;
      W_RESP:  if (BREADY)    w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (RREADY)  w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else if (w_wr_fire) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bresp   <= w_wr_resp;
    end else begin
      if (w_aw_hs) r_aw_held <= 1'b1;
      if (w_w_hs)  r_w_held  <= 1'b1;
    end
  end

  // Payload holding registers are only consulted while their held flag is set.
  always_ff @(posedge ACLK) begin
    if (w_aw_hs) r_awaddr <= AWADDR;
    if (w_w_hs) begin
      r_wdata <= WDATA;
      r_wstrb <= WSTRB;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rresp <= w_rd_resp;
      r_rdata <= (w_rd_resp == RESP_DECERR) ? '0 : w_bank_rdata;
    end
  end

  assign BVALID = (r_wstate == W_RESP);
  assign BRESP  = r_bresp;
  assign RVALID = (r_rstate == R_DATA);
  assign RDATA  = r_rdata;
  assign RRESP  = r_rresp;

  axi4_lite_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK),
    .REG_RESET  (REG_RESET)
  ) u_regbank (
    .i_clk     (ACLK),
    .i_rst     (ARESET),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_wr_addr[LSB +: IDX_W]),
    .i_wr_data (w_wr_data),
    .i_wr_strb (w_wr_strb),
    .i_rd_idx  (ARADDR[LSB +: IDX_W]),
    .o_rd_data (w_bank_rdata),
    .i_reg_in  (REG_IN),
    .o_reg_out (REG_OUT)
  );

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared every
// cycle against an array-based model of the register file.
module tb_axi4_lite_regfile_slave;

  localparam int          NR      = 16;
  localparam logic [15:0] RO      = 16'h0002;
  localparam logic [31:0] RST_VAL = 32'hC0DE_0000;

  logic          ACLK, ARESET;
  logic [31:0]   AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]    WSTRB;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]    BRESP, RRESP;
  logic [NR*32-1:0] REG_OUT, REG_IN;

  axi4_lite_regfile_slave #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .NUM_REGS (NR), .RO_MASK (RO), .REG_RESET (RST_VAL)
  ) dut (
    .ACLK (ACLK), .ARESET (ARESET),
    .AWADDR (AWADDR), .AWVALID (AWVALID), .AWREADY (AWREADY),
    .WDATA (WDATA), .WSTRB (WSTRB), .WVALID (WVALID), .WREADY (WREADY),
    .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
    .ARADDR (ARADDR), .ARVALID (ARVALID), .ARREADY (ARREADY),
    .RDATA (RDATA), .RRESP (RRESP), .RVALID (RVALID), .RREADY (RREADY),
    .REG_OUT (REG_OUT), .REG_IN (REG_IN)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] model_regs [NR];
  bit          model_live = 0;
  bit          exp_bvalid = 0, exp_rvalid = 0;
  logic [1:0]  exp_bresp, exp_rresp;
  logic [31:0] exp_rdata;
  bit          pend_wr = 0, pend_rd = 0;
  logic [31:0] pend_waddr, pend_wdata, pend_rdata;
  logic [3:0]  pend_wstrb;
  logic [1:0]  pend_rresp;
  bit          rand_ready = 0;

  function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                     output logic [1:0] resp);
    int idx;
    if (addr >= 32'd64) begin
      data = 32'h0; resp = 2'b11;
    end else begin
      idx  = int'(addr) / 4;
      resp = 2'b00;
      data = RO[idx] ? REG_IN[idx*32 +: 32] : model_regs[idx];
    end
  endfunction

  always @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NR; i++) model_regs[i] = RO[i] ? 32'h0 : RST_VAL;
      exp_bvalid = 0; exp_rvalid = 0; pend_wr = 0; pend_rd = 0; model_live = 1;
    end else begin
      if (exp_bvalid && BREADY) exp_bvalid = 0;
      if (exp_rvalid && RREADY) exp_rvalid = 0;
      if (pend_wr) begin
        int idx;
        if (pend_waddr >= 32'd64) exp_bresp = 2'b11;
        else begin
          idx = int'(pend_waddr) / 4;
          if (RO[idx]) exp_bresp = 2'b10;
          else begin
            exp_bresp = 2'b00;
            for (int b = 0; b < 4; b++)
              if (pend_wstrb[b]) model_regs[idx][b*8 +: 8] = pend_wdata[b*8 +: 8];
          end
        end
        exp_bvalid = 1; pend_wr = 0;
      end
      if (pend_rd) begin
        exp_rvalid = 1; exp_rdata = pend_rdata; exp_rresp = pend_rresp; pend_rd = 0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge ACLK) begin
    if (model_live) begin
      check("bvalid", {31'b0, BVALID}, {31'b0, exp_bvalid});
      if (exp_bvalid) check("bresp", {30'b0, BRESP}, {30'b0, exp_bresp});
      check("rvalid", {31'b0, RVALID}, {31'b0, exp_rvalid});
      if (exp_rvalid) begin
        check("rdata", RDATA, exp_rdata);
        check("rresp", {30'b0, RRESP}, {30'b0, exp_rresp});
      end
      for (int i = 0; i < NR; i++)
        check($sformatf("reg_out[%0d]", i), REG_OUT[i*32 +: 32], model_regs[i]);
    end
  end

  // ---------------- master tasks (start and end on a falling edge) ----------------
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    while (!(aw_done && w_done)) begin
      if (cyc > 100) begin
        compared++; mismatched++;
        $display("FAIL write_timeout: addr %h never accepted", addr);
        break;
      end
      if (aw_done) check("awready_after_capture", {31'b0, AWREADY}, 32'h0);
      if (w_done)  check("wready_after_capture",  {31'b0, WREADY},  32'h0);
      AWADDR  = addr; AWVALID = !aw_done && (cyc >= aw_dly);
      WDATA   = data; WSTRB   = strb; WVALID = !w_done && (cyc >= w_dly);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      if ((aw_done || aw_hs) && (w_done || w_hs)) begin
        pend_wr = 1; pend_waddr = addr; pend_wdata = data; pend_wstrb = strb;
      end
      @(posedge ACLK);
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      @(negedge ACLK);
      cyc++;
    end
    AWVALID = 0; WVALID = 0;
    check("bvalid_latency", {31'b0, BVALID}, 32'h1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly);
    bit done = 0;
    int cyc = 0;
    while (!done) begin
      if (cyc > 100) begin
        compared++; mismatched++;
        $display("FAIL read_timeout: addr %h never accepted", addr);
        break;
      end
      ARADDR = addr; ARVALID = (cyc >= ar_dly);
      if (ARVALID && ARREADY) begin
        pend_rd = 1; model_read(addr, pend_rdata, pend_rresp); done = 1;
      end
      @(posedge ACLK);
      @(negedge ACLK);
      cyc++;
    end
    ARVALID = 0;
    check("rvalid_latency", {31'b0, RVALID}, 32'h1);
  endtask

  initial begin
    forever begin
      @(negedge ACLK);
      if (rand_ready) begin
        BREADY = ($urandom_range(0, 3) != 0);
        RREADY = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    int          kind, d1, d2;

    ARESET = 1; AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
    AWADDR = 0; WDATA = 0; WSTRB = 0; ARADDR = 0;
    for (int i = 0; i < NR; i++) REG_IN[i*32 +: 32] = $urandom;
    repeat (3) @(negedge ACLK);
    check("reset_out_word0", REG_OUT[31:0], 32'hC0DE_0000);
    check("reset_out_ro_word1", REG_OUT[63:32], 32'h0);
    check("reset_awready", {31'b0, AWREADY}, 32'h0);
    check("reset_rdata", RDATA, 32'h0);
    ARESET = 0;
    @(negedge ACLK);

    // basic write/read
    do_write(32'h0, 32'hA5A5_A5A5, 4'hF, 0, 0);
    check("basic_bresp", {30'b0, BRESP}, 32'h0);
    do_read(32'h0, 0);
    check("basic_rdata", RDATA, 32'hA5A5_A5A5);
    check("basic_rresp", {30'b0, RRESP}, 32'h0);

    // byte strobes
    do_write(32'h0, 32'h1122_3344, 4'b0101, 0, 0);
    do_read(32'h0, 0);
    check("strobe_rdata", RDATA, 32'hA522_A544);

    // split handshake: W three cycles ahead of AW
    do_write(32'h8, 32'hCAFE_F00D, 4'hF, 3, 0);
    check("split_word2", REG_OUT[2*32 +: 32], 32'hCAFE_F00D);

    // errors
    do_write(32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0);
    check("decerr_bresp", {30'b0, BRESP}, 32'h3);
    do_read(32'h40, 0);
    check("decerr_rdata", RDATA, 32'h0);
    check("decerr_rresp", {30'b0, RRESP}, 32'h3);
    do_write(32'h4, 32'h1357_9BDF, 4'hF, 0, 0);
    check("slverr_bresp", {30'b0, BRESP}, 32'h2);
    REG_IN[32 +: 32] = 32'h5EED_0001;
    do_read(32'h4, 1);
    check("ro_rdata", RDATA, 32'h5EED_0001);

    // write backpressure with a concurrent read
    @(negedge ACLK);
    BREADY = 0;
    do_write(32'hC, 32'h1234_5678, 4'hF, 0, 0);
    do_read(32'h0, 0);
    check("stall_read_rdata", RDATA, 32'hA522_A544);
    repeat (4) begin
      check("stall_bvalid", {31'b0, BVALID}, 32'h1);
      check("stall_bresp", {30'b0, BRESP}, 32'h0);
      check("stall_awready", {31'b0, AWREADY}, 32'h0);
      check("stall_wready", {31'b0, WREADY}, 32'h0);
      @(negedge ACLK);
    end
    BREADY = 1;
    @(negedge ACLK);
    check("stall_bvalid_release", {31'b0, BVALID}, 32'h0);

    // read backpressure
    RREADY = 0;
    do_read(32'h8, 0);
    repeat (5) begin
      check("rstall_rvalid", {31'b0, RVALID}, 32'h1);
      check("rstall_rdata", RDATA, 32'hCAFE_F00D);
      check("rstall_arready", {31'b0, ARREADY}, 32'h0);
      @(negedge ACLK);
    end
    RREADY = 1;
    @(negedge ACLK);
    check("rstall_rvalid_release", {31'b0, RVALID}, 32'h0);

    // reset mid-write with AW already captured
    AWADDR = 32'h10; AWVALID = 1;
    check("pre_reset_awready", {31'b0, AWREADY}, 32'h1);
    @(negedge ACLK);
    AWVALID = 0; ARESET = 1;
    repeat (2) begin
      @(negedge ACLK);
      check("rst_awready", {31'b0, AWREADY}, 32'h0);
      check("rst_wready", {31'b0, WREADY}, 32'h0);
      check("rst_arready", {31'b0, ARREADY}, 32'h0);
      check("rst_bvalid", {31'b0, BVALID}, 32'h0);
      check("rst_rvalid", {31'b0, RVALID}, 32'h0);
      check("rst_word0", REG_OUT[31:0], 32'hC0DE_0000);
      check("rst_word3", REG_OUT[3*32 +: 32], 32'hC0DE_0000);
    end
    ARESET = 0;
    @(negedge ACLK);
    @(negedge ACLK);
    check("post_rst_awready", {31'b0, AWREADY}, 32'h1);
    check("post_rst_bresp", {30'b0, BRESP}, 32'h0);
    // W alone must not complete against the discarded AW
    do_write(32'h14, 32'h0F0F_0F0F, 4'hF, 4, 0);
    check("post_rst_word5", REG_OUT[5*32 +: 32], 32'h0F0F_0F0F);
    check("post_rst_word4", REG_OUT[4*32 +: 32], 32'hC0DE_0000);

    // randomized traffic
    rand_ready = 1;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NR; i++) REG_IN[i*32 +: 32] = $urandom;
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1, 2:    a = $urandom_range(0, 32'h4F);
        default: a = 32'(4 * $urandom_range(0, 3));
      endcase
      d  = $urandom;
      s  = 4'($urandom);
      d1 = $urandom_range(0, 2);
      d2 = $urandom_range(0, 2);
      kind = $urandom_range(0, 2);
      if (kind == 0) do_write(a, d, s, d1, d2);
      else if (kind == 1) do_read(a, d1);
      else begin
        fork
          do_write(a, d, s, d1, d2);
          do_read(32'(4 * $urandom_range(0, 3)), d2);
        join
      end
    end
    rand_ready = 0;
    BREADY = 1; RREADY = 1;
    repeat (4) @(negedge ACLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
